// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : State encoding and width helper shared by the chunked adder.
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so a single-chunk counter still has a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunked_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : chunked_adder_if
// Brief    : Operand/result valid-ready bundle for the chunked adder.
// Revision : 1.0 - initial release
// ============================================================================
interface chunked_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ============================================================================
// Module   : adder_chunk
// Brief    : Combinational CHUNK-bit adder with carry in and carry out.
// Revision : 1.0 - initial release
// ============================================================================
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  wire logic [CHUNK-1:0] i_a,
    input  wire logic [CHUNK-1:0] i_b,
    input  wire logic             i_cin,
    output logic      [CHUNK-1:0] o_sum,
    output logic                  o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
endmodule
`default_nettype wire

// File: rtl/chunked_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunked_adder
// Brief    : Multi-cycle add/sub, CHUNK bits per clock LSB first, with
//            carry-out and signed-overflow flags and valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    chunked_adder_if.slave bus
);
    localparam int                 c_N     = WIDTH / CHUNK;
    localparam int                 c_CNT_W = clog2_min1(c_N);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_N - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_chunk_sum;
    logic               w_chunk_cout;
    logic               w_accept;
    logic               w_last;

    assign w_accept  = (r_state == IDLE) && bus.in_valid;
    assign w_last    = (r_cnt == c_LAST);
    assign w_a_chunk = r_a[r_cnt*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_cnt*CHUNK +: CHUNK];

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_cin  (r_carry),
        .o_sum  (w_chunk_sum),
        .o_cout (w_chunk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next_state = BUSY;
            BUSY:    if (w_last)        w_next_state = DONE;
            DONE:    if (bus.out_ready) w_next_state = IDLE;
            default:                    w_next_state = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted on capture and the +1 rides
    // in as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_cnt   <= '0;
        end else if (r_state == BUSY) begin
            r_sum[r_cnt*CHUNK +: CHUNK] <= w_chunk_sum;
            r_carry                     <= w_chunk_cout;
            if (w_last) begin
                r_cout <= w_chunk_cout;
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                          (w_chunk_sum[CHUNK-1] != r_a[WIDTH-1]);
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_adder
// Brief    : Self-checking bench for chunked_adder (16/4, 4/1 and 4/4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_adder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    chunked_adder_if #(.WIDTH(16)) bus16 ();
    chunked_adder_if #(.WIDTH(4))  bus41 ();
    chunked_adder_if #(.WIDTH(4))  bus44 ();

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    chunked_adder #(.WIDTH(4),  .CHUNK(1)) dut41 (.clk(clk), .rst_n(rst_n), .bus(bus41));
    chunked_adder #(.WIDTH(4),  .CHUNK(4)) dut44 (.clk(clk), .rst_n(rst_n), .bus(bus44));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; packs {ovf, cout, sum[15:0]}.
    function automatic logic [17:0] model(input int w, input int a, input int b, input bit s);
        longint lim, r, sa, sb, sr;
        logic [17:0] res;
        lim = longint'(1) << (w - 1);
        r   = s ? longint'(a) - longint'(b) : longint'(a) + longint'(b);
        sa  = (a >= lim) ? a - 2 * lim : longint'(a);
        sb  = (b >= lim) ? b - 2 * lim : longint'(b);
        sr  = s ? sa - sb : sa + sb;
        res = '0;
        res[15:0] = 16'(r & (2 * lim - 1));
        res[16]   = s ? (a >= b) : (r >= 2 * lim);
        res[17]   = (sr >= lim) || (sr < -lim);
        return res;
    endfunction

    function automatic logic [17:0] obs16();
        return {bus16.ovf, bus16.cout, bus16.sum};
    endfunction

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int n;
        n = 0;
        while (!bus16.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_start", 32'(bus16.in_ready), 32'd1);
        bus16.a        = a;
        bus16.b        = b;
        bus16.sub      = s;
        bus16.in_valid = 1'b1;
        @(negedge clk);
        bus16.in_valid = 1'b0;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input string tag, input bit noise, input int hold,
                        output int lat, output logic [17:0] res);
        logic [17:0] exp;
        start16(a, b, s);
        lat = 0;
        while (!bus16.out_valid && lat < 50) begin
            if (noise) begin
                bus16.in_valid = 1'($urandom);
                bus16.a        = 16'($urandom);
                bus16.b        = 16'($urandom);
                bus16.sub      = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_valid"}, 32'(bus16.out_valid), 32'd1);
        exp = model(16, int'(a), int'(b), s);
        res = obs16();
        chk({tag, "_result"}, 32'(res), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                bus16.in_valid = 1'($urandom);
                bus16.a        = 16'($urandom);
                bus16.b        = 16'($urandom);
            end
            @(negedge clk);
            chk({tag, "_hold_result"}, 32'(obs16()), 32'(exp));
            chk({tag, "_hold_flags"}, {30'd0, bus16.in_ready, bus16.out_valid}, 32'b01);
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        @(negedge clk);
        bus16.out_ready = 1'b0;
        chk({tag, "_back_idle"}, {30'd0, bus16.in_ready, bus16.out_valid}, 32'b10);
    endtask

    initial begin
        int          lat;
        logic [17:0] res;
        int          n, lat41, lat44;
        logic [17:0] exp4;

        bus16.in_valid = 0; bus16.a = '0; bus16.b = '0; bus16.sub = 0; bus16.out_ready = 0;
        bus41.in_valid = 0; bus41.a = '0; bus41.b = '0; bus41.sub = 0; bus41.out_ready = 0;
        bus44.in_valid = 0; bus44.a = '0; bus44.b = '0; bus44.sub = 0; bus44.out_ready = 0;

        repeat (2) @(negedge clk);
        chk("reset_flags", {28'd0, bus16.in_ready, bus16.out_valid, bus16.cout, bus16.ovf}, 32'b1000);
        chk("reset_sum", 32'(bus16.sum), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases with hand-derived results.
        op16(16'hFFFF, 16'h0001, 1'b0, "wrap", 1'b0, 0, lat, res);
        chk("wrap_latency", 32'(lat), 32'd4);
        chk("wrap_const", 32'(res), 32'h10000);
        op16(16'h7FFF, 16'h0001, 1'b0, "sovf_add", 1'b0, 0, lat, res);
        chk("sovf_add_const", 32'(res), 32'h28000);
        op16(16'h8000, 16'h0001, 1'b1, "sovf_sub", 1'b0, 0, lat, res);
        chk("sovf_sub_const", 32'(res), 32'h37FFF);
        op16(16'h0005, 16'h0007, 1'b1, "borrow", 1'b0, 0, lat, res);
        chk("borrow_const", 32'(res), 32'h0FFFE);

        // Backpressure, then input noise while busy and done.
        op16(16'hA5A5, 16'h5A5A, 1'b0, "hold", 1'b0, 10, lat, res);
        op16(16'h1357, 16'h2468, 1'b1, "noise", 1'b1, 5, lat, res);

        // Reset in the second BUSY cycle.
        start16(16'h0F0F, 16'h0101, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {28'd0, bus16.in_ready, bus16.out_valid, bus16.cout, bus16.ovf}, 32'b1000);
        chk("midrst_sum", 32'(bus16.sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("postrst_idle", {30'd0, bus16.in_ready, bus16.out_valid}, 32'b10);
        op16(16'h1234, 16'h1111, 1'b0, "postrst", 1'b0, 0, lat, res);
        chk("postrst_const", 32'(res), 32'h02345);

        // Randomized operations against the reference model.
        repeat (40) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), "rand",
                 1'($urandom), int'($urandom_range(3, 0)), lat, res);
            chk("rand_latency", 32'(lat), 32'd4);
        end

        // Exhaustive 4-bit sweep on the CHUNK=1 and CHUNK=4 builds together.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int s = 0; s < 2; s++) begin
                    bus41.a = 4'(a); bus41.b = 4'(b); bus41.sub = 1'(s); bus41.in_valid = 1'b1;
                    bus44.a = 4'(a); bus44.b = 4'(b); bus44.sub = 1'(s); bus44.in_valid = 1'b1;
                    @(negedge clk);
                    bus41.in_valid = 1'b0;
                    bus44.in_valid = 1'b0;
                    n = 0; lat41 = 0; lat44 = 0;
                    while (!(bus41.out_valid && bus44.out_valid) && n < 50) begin
                        @(negedge clk);
                        n++;
                        if (bus41.out_valid && lat41 == 0) lat41 = n;
                        if (bus44.out_valid && lat44 == 0) lat44 = n;
                    end
                    exp4 = model(4, a, b, 1'(s));
                    chk("sweep_w4c1", {14'd0, bus41.ovf, bus41.cout, 12'd0, bus41.sum}, 32'(exp4));
                    chk("sweep_w4c4", {14'd0, bus44.ovf, bus44.cout, 12'd0, bus44.sum}, 32'(exp4));
                    chk("sweep_lat_c1", 32'(lat41), 32'd4);
                    chk("sweep_lat_c4", 32'(lat44), 32'd1);
                    bus41.out_ready = 1'b1;
                    bus44.out_ready = 1'b1;
                    @(negedge clk);
                    bus41.out_ready = 1'b0;
                    bus44.out_ready = 1'b0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first, and carries between chunks in a register. It is the next-generation replacement for the fixed 4-bit combinational adder. It gives datapath blocks a wide add/sub with a short critical path, carry-out and signed-overflow flags, and valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A, unsigned/two's complement
- b  in  WIDTH  operand B
- sub  in  1  0: A+B, 1: A−B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB; for sub, 1 = no borrow
- ovf  out  1  signed two's-complement overflow

## Operation
- N = WIDTH/CHUNK. States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a; latch b, or ~b when sub=1; load carry with sub; clear chunk counter; go to BUSY.
- BUSY:
  - Each cycle, add chunk k of A and B plus the carry register.
  - Write the CHUNK result bits into sum[k*CHUNK +: CHUNK] and store the chunk carry-out.
  - k increments. After chunk N−1, go to DONE.
  - cout = final carry. ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the inverted B for sub.
- DONE:
  - out_valid=1. sum, cout and ovf stay stable.
  - On out_ready, go to IDLE.
- in_ready is 0 in BUSY and DONE. Inputs are ignored there; no queuing.
- No same-cycle bypass: the IDLE→BUSY handshake and the DONE→IDLE handshake are separate cycles.
- sum, cout and ovf are only meaningful while out_valid=1. Intermediate sum bits may be visible during BUSY.
- Reset (rst_n low, at any time including mid-BUSY):
  - State goes to IDLE immediately and any in-flight operation is discarded.
  - out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 once in IDLE.
  - Chunk counter, carry and operand registers are cleared.

## Timing
- Acceptance at edge T0 → BUSY for N cycles → out_valid rises after edge TN (latency N cycles).
- Output handshake at edge Td → in_ready high after Td.
- Best-case throughput: one operation per N+2 cycles.
- N=1 (CHUNK=WIDTH) is legal: one BUSY cycle, then DONE.
- Counter width is clog2(N), minimum 1. The counter must not wrap in BUSY; the terminal compare is at N−1.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Structure
- adder_pkg holds the state encoding (IDLE/BUSY/DONE) and a clog2 helper, shared with future datapath blocks.
- Sub-module adder_chunk: combinational CHUNK-bit add with carry in/out. It is instantiated once, and the top level muxes the operand slices into it by counter.
- Top level contains the FSM, counter, operand/result registers and flag logic.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated otherwise.
1. Unsigned add wrap-around: a=0xFFFF, b=0x0001, sub=0 → sum=0x0000, cout=1, ovf=0; out_valid exactly 4 cycles after acceptance.
2. Signed overflow: a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
3. Subtract with borrow: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0.
4. Backpressure:
   - Hold out_ready=0 for 10 cycles in DONE → sum/cout/ovf stable, in_ready=0.
   - Toggle in_valid with changing operands during BUSY/DONE → result unaffected.
5. Reset mid-operation: assert rst_n=0 during BUSY cycle 2 → out_valid=0, sum=0, in_ready=1 after release. The next operation, 0x1234+0x1111, gives 0x2345.
6. Exhaustive sweep with WIDTH=4, CHUNK=1 and with CHUNK=4, both modes:
   - Check all 256×2 operand/mode combinations against a golden model: sum/cout from the 5-bit a+b or a+~b+1, and ovf from the sign rule.
   - Any mismatch prints ERROR.
